// File: rtl/per_slave_arbiter_pkg.sv
// Shared types and constants for the per_slave_arbiter slice.
package per_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } per_arb_state_e;

    localparam logic [31:0] PER_ARB_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/per_slave_arbiter_if.sv
// Single peripheral-interconnect channel: request fields out, grant and response back.
interface per_slave_arbiter_if #(
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned PER_ID_WIDTH   = 1
);
    logic                      req;
    logic [PER_ADDR_WIDTH-1:0] add;
    logic                      wen;
    logic [31:0]               wdata;
    logic [3:0]                be;
    logic [PER_ID_WIDTH-1:0]   id;
    logic                      gnt;
    logic                      r_valid;
    logic                      r_opc;
    logic [PER_ID_WIDTH-1:0]   r_id;
    logic [31:0]               r_rdata;

    modport master (
        output req, add, wen, wdata, be, id,
        input  gnt, r_valid, r_opc, r_id, r_rdata
    );

    modport slave (
        input  req, add, wen, wdata, be, id,
        output gnt, r_valid, r_opc, r_id, r_rdata
    );
endinterface

// File: rtl/per_slave_arbiter_rr_arbiter.sv
// Combinational rotating-priority encoder: ptr_i is the highest-priority index.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);
    int unsigned j;

    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        j       = 0;
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int i = N - 1; i >= 0; i--) begin
            j = (32'(ptr_i) + 32'(i)) % N;
            if (req_i[j]) idx_o = IdxW'(j);
        end
    end
endmodule

// File: rtl/per_slave_arbiter.sv
// Round-robin sharing of one peripheral slave port, one outstanding transaction.
// Define PER_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module per_slave_arbiter
    import per_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS      = 4,
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned PER_ID_WIDTH   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [N_MASTERS-1:0]                     m_req_i,
    input  logic [N_MASTERS-1:0][PER_ADDR_WIDTH-1:0] m_add_i,
    input  logic [N_MASTERS-1:0]                     m_wen_i,
    input  logic [N_MASTERS-1:0][31:0]               m_wdata_i,
    input  logic [N_MASTERS-1:0][3:0]                m_be_i,
    input  logic [N_MASTERS-1:0][PER_ID_WIDTH-1:0]   m_id_i,
    output logic [N_MASTERS-1:0]                     m_gnt_o,
    output logic [N_MASTERS-1:0]                     m_r_valid_o,
    output logic                                     m_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]                  m_r_id_o,
    output logic [31:0]                              m_r_rdata_o,
    per_slave_arbiter_if.master                      per_slave,
    output logic                                     busy_o,
    output logic                                     stray_o,
    output logic                                     timeout_o
);
    localparam int unsigned IdxW = $clog2(N_MASTERS);

    per_arb_state_e  state_q;
    logic [IdxW-1:0] owner_q, ptr_q, owner_inc, win_idx;
    logic            win_valid, owner_req, resp_done, expire, stray_q;

    rr_arbiter #(.N(N_MASTERS)) u_rr (
        .req_i  (m_req_i),
        .ptr_i  (ptr_q),
        .idx_o  (win_idx),
        .valid_o(win_valid)
    );

    assign owner_req = m_req_i[owner_q];
    assign owner_inc = (32'(owner_q) == N_MASTERS - 1) ? '0 : owner_q + 1'b1;
    assign resp_done = (state_q == WAIT) && per_slave.r_valid;

`ifdef PER_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q;
    logic            timeout_q;

    // A real response in the limit cycle takes precedence over the watchdog.
    assign expire = (state_q == WAIT) && !per_slave.r_valid && (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q != WAIT) cnt_q <= '0;
            else if (!per_slave.r_valid && !expire) cnt_q <= cnt_q + 1'b1;
            if (expire) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign per_slave.req   = (state_q == REQ) && owner_req;
    assign per_slave.add   = m_add_i[owner_q];
    assign per_slave.wen   = m_wen_i[owner_q];
    assign per_slave.wdata = m_wdata_i[owner_q];
    assign per_slave.be    = m_be_i[owner_q];
    assign per_slave.id    = m_id_i[owner_q];

    always_comb begin
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        if ((state_q == REQ) && owner_req && per_slave.gnt) m_gnt_o[owner_q] = 1'b1;
        if (resp_done || expire) m_r_valid_o[owner_q] = 1'b1;
    end

    assign m_r_opc_o   = expire ? 1'b1 : per_slave.r_opc;
    assign m_r_rdata_o = expire ? PER_ARB_TIMEOUT_DATA : per_slave.r_rdata;
    assign m_r_id_o    = per_slave.r_id;
    assign busy_o      = (state_q != IDLE);
    assign stray_o     = stray_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            stray_q <= 1'b0;
        end else begin
            if ((state_q != WAIT) && per_slave.r_valid) stray_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        owner_q <= win_idx;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (!owner_req) state_q <= IDLE;
                    else if (per_slave.gnt) state_q <= WAIT;
                end
                WAIT: begin
                    if (resp_done || expire) begin
                        ptr_q   <= owner_inc;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_per_slave_arbiter.sv
// Directed self-checking bench for per_slave_arbiter (4 masters, TIMEOUT_CYCLES = 8).
module tb_per_slave_arbiter;
    logic             clk = 1'b0;
    logic             rst_ni;
    logic [3:0]       m_req, m_wen, m_gnt, m_rv;
    logic [3:0][31:0] m_add, m_wdata;
    logic [3:0][3:0]  m_be;
    logic [3:0][0:0]  m_id;
    logic             m_opc, busy, stray, tmo;
    logic [0:0]       m_rid;
    logic [31:0]      m_rdata;
    int               checks = 0;
    int               failures = 0;

    per_slave_arbiter_if #(.PER_ADDR_WIDTH(32), .PER_ID_WIDTH(1)) ps ();

    per_slave_arbiter #(
        .N_MASTERS(4), .PER_ADDR_WIDTH(32), .PER_ID_WIDTH(1), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_req_i(m_req), .m_add_i(m_add), .m_wen_i(m_wen), .m_wdata_i(m_wdata),
        .m_be_i(m_be), .m_id_i(m_id),
        .m_gnt_o(m_gnt), .m_r_valid_o(m_rv), .m_r_opc_o(m_opc), .m_r_id_o(m_rid),
        .m_r_rdata_o(m_rdata), .per_slave(ps.master),
        .busy_o(busy), .stray_o(stray), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change right after the falling edge; outputs are checked 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni   = 1'b0;
        m_req    = '0;
        m_wen    = '1;
        m_add    = '0;
        m_wdata  = '0;
        m_be     = '0;
        m_id     = '0;
        ps.gnt   = 1'b0;
        ps.r_valid = 1'b0;
        ps.r_opc = 1'b0;
        ps.r_id  = '0;
        ps.r_rdata = '0;
        #1;
        chk("rst_gnt", 32'(m_gnt), 32'h0);
        chk("rst_rv", 32'(m_rv), 32'h0);
        chk("rst_req", 32'(ps.req), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_stray", 32'(stray), 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);
        step();
        rst_ni = 1'b1;

        // Single write from master 2
        step();
        m_req = 4'b0100; m_add[2] = 32'h1C000010; m_wen[2] = 1'b0;
        m_wdata[2] = 32'hA5A5_0F0F; m_be[2] = 4'hF; ps.gnt = 1'b1;
        #1 chk("t1_c0_req", 32'(ps.req), 32'h0);
        step();
        #1;
        chk("t1_c1_req", 32'(ps.req), 32'h1);
        chk("t1_c1_add", ps.add, 32'h1C000010);
        chk("t1_c1_wen", 32'(ps.wen), 32'h0);
        chk("t1_c1_wdata", ps.wdata, 32'hA5A5_0F0F);
        chk("t1_c1_be", 32'(ps.be), 32'hF);
        chk("t1_c1_gnt", 32'(m_gnt), 32'h4);
        step();
        m_req = '0; ps.gnt = 1'b0; ps.r_valid = 1'b1; ps.r_rdata = 32'h1234_5678; ps.r_id = 1'b1;
        #1;
        chk("t1_c2_rv", 32'(m_rv), 32'h4);
        chk("t1_c2_rdata", m_rdata, 32'h1234_5678);
        chk("t1_c2_rid", 32'(m_rid), 32'h1);
        chk("t1_c2_opc", 32'(m_opc), 32'h0);
        chk("t1_c2_gnt", 32'(m_gnt), 32'h0);
        step();
        ps.r_valid = 1'b0;
        #1;
        chk("t1_c3_busy", 32'(busy), 32'h0);
        chk("t1_c3_rv", 32'(m_rv), 32'h0);

        // All four masters request continuously; grants 0,1,2,3,0 every third cycle
        reset_pulse();
        for (int k = 0; k < 15; k++) begin
            if (k > 0) step();
            m_req = 4'b1111; ps.gnt = 1'b1; ps.r_valid = (k % 3 == 2);
            #1;
            chk($sformatf("rr_gnt_%0d", k), 32'(m_gnt),
                (k % 3 == 1) ? (32'h1 << ((k / 3) % 4)) : 32'h0);
            chk($sformatf("rr_rv_%0d", k), 32'(m_rv),
                (k % 3 == 2) ? (32'h1 << ((k / 3) % 4)) : 32'h0);
        end

        // Master 1 withdraws in REQ; pointer (1) must not advance
        step();
        m_req = 4'b0010; ps.gnt = 1'b0; ps.r_valid = 1'b0;
        step();
        #1;
        chk("drop_c1_req", 32'(ps.req), 32'h1);
        chk("drop_c1_gnt", 32'(m_gnt), 32'h0);
        step();
        m_req = 4'b0000;
        #1;
        chk("drop_c2_req", 32'(ps.req), 32'h0);
        chk("drop_c2_gnt", 32'(m_gnt), 32'h0);
        chk("drop_c2_busy", 32'(busy), 32'h1);
        step();
        m_req = 4'b1010; ps.gnt = 1'b1;
        #1 chk("drop_c3_busy", 32'(busy), 32'h0);
        step();
        #1 chk("drop_c4_gnt", 32'(m_gnt), 32'h2);
        step();
        m_req = 4'b1000; ps.gnt = 1'b0; ps.r_valid = 1'b1;
        #1 chk("drop_c5_rv", 32'(m_rv), 32'h2);
        step();
        m_req = 4'b0000; ps.r_valid = 1'b0;
        #1 chk("drop_c6_busy", 32'(busy), 32'h0);

        // Stray response in IDLE
        step();
        ps.r_valid = 1'b1;
        #1;
        chk("stray_rv", 32'(m_rv), 32'h0);
        chk("stray_pre", 32'(stray), 32'h0);
        step();
        ps.r_valid = 1'b0;
        #1 chk("stray_set", 32'(stray), 32'h1);
        step();
        #1 chk("stray_sticky", 32'(stray), 32'h1);

        // Reset during WAIT, then a late response is stray
        step();
        m_req = 4'b0001; ps.gnt = 1'b1;
        step();
        #1 chk("rw_gnt", 32'(m_gnt), 32'h1);
        step();
        m_req = '0; ps.gnt = 1'b0;
        #1 chk("rw_busy_wait", 32'(busy), 32'h1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rw_busy_rst", 32'(busy), 32'h0);
        chk("rw_rv_rst", 32'(m_rv), 32'h0);
        chk("rw_req_rst", 32'(ps.req), 32'h0);
        chk("rw_stray_rst", 32'(stray), 32'h0);
        step();
        rst_ni = 1'b1; ps.r_valid = 1'b1;
        #1 chk("rw_late_rv", 32'(m_rv), 32'h0);
        step();
        ps.r_valid = 1'b0;
        #1 chk("rw_late_stray", 32'(stray), 32'h1);

`ifdef PER_ARB_TIMEOUT_EN
        // Slave never responds: watchdog answers on the 9th WAIT cycle
        reset_pulse();
        m_req = 4'b0100; ps.gnt = 1'b1;
        step();
        #1 chk("to_gnt", 32'(m_gnt), 32'h4);
        for (int i = 0; i < 8; i++) begin
            step();
            m_req = '0; ps.gnt = 1'b0;
            #1 chk($sformatf("to_wait_rv_%0d", i), 32'(m_rv), 32'h0);
        end
        step();
        #1;
        chk("to_rv", 32'(m_rv), 32'h4);
        chk("to_opc", 32'(m_opc), 32'h1);
        chk("to_rdata", m_rdata, 32'hDEADBEEF);
        step();
        #1;
        chk("to_flag", 32'(tmo), 32'h1);
        chk("to_busy", 32'(busy), 32'h0);
`else
        chk("tmo_tied", 32'(tmo), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/per_slave_arbiter.md
# per_slave_arbiter

Round-robin arbiter that shares one peripheral-interconnect slave port among N_MASTERS testbench/boot masters, such as L2 preloaders, stimulus drivers and result checkers. It sits between those masters and the L2/peripheral slave port. It allows exactly one outstanding transaction at a time and routes each response back to the master that issued the request. An optional watchdog converts a lost response into an error response so the bench cannot hang.

## Interface
- N_MASTERS, 4, number of requesting masters (≥2)
- PER_ADDR_WIDTH, 32, address width
- PER_ID_WIDTH, 1, transaction ID width
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT (used only with the macro)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- m_req_i  in  [N_MASTERS]  master request
- m_add_i  in  [N_MASTERS][PER_ADDR_WIDTH]  master address
- m_wen_i  in  [N_MASTERS]  write-enable, 0 = write (interconnect convention)
- m_wdata_i  in  [N_MASTERS][32]  write data
- m_be_i  in  [N_MASTERS][4]  byte enables
- m_id_i  in  [N_MASTERS][PER_ID_WIDTH]  master ID
- m_gnt_o  out  [N_MASTERS]  grant, one-hot or zero
- m_r_valid_o  out  [N_MASTERS]  response valid, one-hot or zero
- m_r_opc_o  out  1  response error flag, broadcast
- m_r_id_o  out  PER_ID_WIDTH  response ID, broadcast
- m_r_rdata_o  out  32  response data, broadcast
- per_slave_req_o, per_slave_add_o, per_slave_wen_o, per_slave_wdata_o, per_slave_be_o, per_slave_id_o  out  slave request channel, widths as per master fields
- per_slave_gnt_i  in  1  slave grant
- per_slave_r_valid_i, per_slave_r_opc_i, per_slave_r_id_i, per_slave_r_rdata_i  in  slave response channel
- busy_o  out  1  a transaction is in flight (state ≠ IDLE)
- stray_o  out  1  sticky: a response arrived when none was expected
- timeout_o  out  1  sticky: the watchdog fired

## Operation
- FSM states:
  - IDLE: if any m_req_i is high, latch owner = round-robin winner starting at the pointer and go to REQ. Otherwise stay in IDLE.
  - REQ: per_slave_req_o = m_req_i[owner]; all request fields are muxed from owner.
    - If per_slave_gnt_i is high, m_gnt_o[owner] = 1 combinationally and the FSM goes to WAIT.
    - If m_req_i[owner] drops before the grant, go to IDLE with no grant issued and the pointer unchanged.
  - WAIT: per_slave_req_o = 0.
    - If per_slave_r_valid_i is high, m_r_valid_o[owner] = 1 in the same cycle, r_opc/id/rdata pass through, pointer = (owner+1) mod N_MASTERS, and the FSM goes to IDLE.
- Round-robin: the pointer is the highest-priority index and advances only on a completed response.
- Stray responses: per_slave_r_valid_i in IDLE or REQ sets stray_o. It is not forwarded to any master and does not change state.
- Slave request fields are muxed from owner in every state; m_r_* data fields pass through from the slave continuously.

## Timing
- Reset values: state = IDLE, owner = 0, pointer = 0.
  - All req, gnt and r_valid outputs are 0.
  - busy_o, stray_o and timeout_o are 0.
- Reset is honoured in any state, including mid-WAIT. A response arriving after reset is treated as stray.
- Request latency: a master request first seen in cycle 0 reaches per_slave_req_o in cycle 1. The earliest grant is cycle 1 and the earliest response is cycle 2.
- Response-to-next-request: the cycle after the response is spent in IDLE for re-arbitration, so the minimum period is 3 cycles per transaction.
- Masters must hold their request fields stable from req until gnt.

## Configuration
- PER_ARB_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle without r_valid.
  - When it reaches TIMEOUT_CYCLES, the arbiter sets m_r_valid_o[owner] = 1, m_r_opc_o = 1 and m_r_rdata_o = 32'hDEADBEEF, sets timeout_o, advances the pointer and goes to IDLE.
  - If r_valid arrives in the same cycle the counter reaches the limit, the real response wins.
- PER_ARB_TIMEOUT_EN undefined: WAIT persists until r_valid, no counter is synthesised, and timeout_o is tied to 0.

## Structure
- Package per_arb_pkg holds:
  - the state enum typedef {IDLE, REQ, WAIT} as logic [1:0]
  - the constant PER_ARB_TIMEOUT_DATA = 32'hDEADBEEF
- One sub-module, rr_arbiter: a combinational rotating-priority encoder that takes (req vector, pointer) and returns (winner index, valid).

## Test plan
- Master 2 alone writes 0x1C000010; the slave grants at once and responds one cycle later -> req_o is high in cycle 1 with add_o = 0x1C000010, m_gnt_o = 4'b0100, m_r_valid_o = 4'b0100 in cycle 2, and busy_o drops in cycle 3.
- All four masters hold req continuously with a 1-cycle response -> grants go 0,1,2,3,0, each 3 cycles apart.
- Master 1 drops req while in REQ without a grant -> no gnt, the FSM returns to IDLE, and the next grant goes to master 1 if it re-requests, since the pointer did not advance.
- The slave raises r_valid while the arbiter is in IDLE -> stray_o rises and stays high, and all m_r_valid_o = 0.
- rst_ni is asserted during WAIT -> outputs are 0 immediately, and a response afterwards sets stray_o.
- With PER_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, the slave never responds -> 8 cycles after entering WAIT, the owner sees r_valid with opc = 1 and rdata = 0xDEADBEEF, and timeout_o = 1.
